// File: rtl/spi_cmd_tx.sv
// SPI mode-0 command transmitter: shifts {cmd_word, data_word} out MSB first
// inside one CSB frame, with lead, trail and inter-packet gap of one SCLK half-period each.
module spi_cmd_tx #(
  parameter int PACKET_WIDTH = 24,
  parameter int DATA_WIDTH   = PACKET_WIDTH - 8,
  parameter int HALF_PERIOD  = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [7:0]            cmd_word,
  input  logic [DATA_WIDTH-1:0] data_word,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);

  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam int BW = $clog2(PACKET_WIDTH) + 1;
  localparam logic [HW-1:0] H_RELOAD = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] B_RELOAD = BW'(PACKET_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t                  state_q;
  logic [HW-1:0]           hcnt_q;
  logic [BW-1:0]           bcnt_q;
  logic [PACKET_WIDTH-1:0] shreg_q;
  logic                    busy_q, done_q, sclk_q, mosi_q, csb_q;
  logic                    hp_end;

  assign hp_end = (hcnt_q == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csb_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // accepting in the done cycle is what makes the CSB-high gap H+1
          if (start) begin
            shreg_q <= PACKET_WIDTH'({cmd_word, data_word});
            mosi_q  <= cmd_word[7];
            csb_q   <= 1'b0;
            busy_q  <= 1'b1;
            hcnt_q  <= H_RELOAD;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          if (hp_end) begin
            sclk_q  <= 1'b1;
            hcnt_q  <= H_RELOAD;
            bcnt_q  <= B_RELOAD;
            state_q <= SHIFT;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        SHIFT: begin
          if (hp_end) begin
            hcnt_q <= H_RELOAD;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              // last falling edge leaves the LSB on mosi
              if (bcnt_q == '0) begin
                state_q <= TRAIL;
              end else begin
                shreg_q <= {shreg_q[PACKET_WIDTH-2:0], 1'b0};
                mosi_q  <= shreg_q[PACKET_WIDTH-2];
                bcnt_q  <= bcnt_q - 1'b1;
              end
            end
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        TRAIL: begin
          if (hp_end) begin
            csb_q   <= 1'b1;
            hcnt_q  <= H_RELOAD;
            state_q <= GAP;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        GAP: begin
          if (hp_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign csb  = csb_q;

endmodule
